// File: rtl/uart_pkg.sv
// UART receiver shared definitions.
// FSM encoding and default timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // 12.5 MHz / (19200 * 16)
    localparam int BAUD_DIV_DEF = 41;
    localparam int SB_TICK_DEF  = 16;

    // Oversample tick counts within one bit period
    localparam int MID_TICK  = 7;
    localparam int LAST_TICK = 15;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator.
// Free-running divider, one-clk tick per BAUD_DIV clocks.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap the divider at its terminal count
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled, LSB-first framing.
// Sticky status flags cleared by a consumer acknowledge.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            uartRx,
    input  logic            rd_ack,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            data_available,
    output logic            frame_err,
    output logic            overrun
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            tick;
    logic            meta_q;
    logic            rxs_q;
    rx_state_e       state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] sr_q, sr_d;
    logic            good_d;
    logic            bad_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q;
    logic            dav_q, dav_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Two-flop synchronizer, preset to the idle line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= uartRx;
            rxs_q  <= meta_q;
        end
    end

    // Frame FSM: start validation, bit sampling, stop check
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sr_d    = sr_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'(MID_TICK)) begin
                        if (!rxs_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'(LAST_TICK)) begin
                        sr_d = {rxs_q, sr_q[DBIT-1:1]};
                        s_d  = '0;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        good_d  = rxs_q;
                        bad_d   = !rxs_q;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // Output data and sticky flags; a completing frame wins over an ack
    always_comb begin
        data_d = good_d ? sr_q : data_q;
        dav_d  = dav_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (done_q) begin
            dav_d = 1'b1;
        end else if (rd_ack) begin
            dav_d = 1'b0;
        end
        if (bad_d) begin
            ferr_d = 1'b1;
        end else if (rd_ack) begin
            ferr_d = 1'b0;
        end
        if (done_q && dav_q && !rd_ack) begin
            ovr_d = 1'b1;
        end else if (rd_ack) begin
            ovr_d = 1'b0;
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            dav_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            done_q  <= good_d;
            dav_q   <= dav_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data        = data_q;
    assign rx_done        = done_q;
    assign data_available = dav_q;
    assign frame_err      = ferr_q;
    assign overrun        = ovr_q;

endmodule

// File: doc/uart_rx_unit.md
UART_RX_UNIT -- requirements
Module: uart_rx_unit

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 41, meaning clk cycles per oversample tick (12.5 MHz / (19200*16)).
REQ-002 The block SHALL have parameter DBIT, default 8, meaning data bits per frame.
REQ-003 The block SHALL have parameter SB_TICK, default 16, meaning oversample ticks in the stop bit.
REQ-004 Port clk SHALL be input, width 1, the single clock; all logic is on its rising edge.
REQ-005 Port reset SHALL be input, width 1, asynchronous active-high reset.
REQ-006 Port uartRx SHALL be input, width 1, asynchronous serial line that idles high.
REQ-007 Port rd_ack SHALL be input, width 1, consumer acknowledge that clears data_available.
REQ-008 Port rx_data SHALL be output, width DBIT, last good received byte.
REQ-009 Port rx_done SHALL be output, width 1, one-cycle pulse when a good frame completes.
REQ-010 Port data_available SHALL be output, width 1, sticky flag for an unread byte (drives ledDataAvailable).
REQ-011 Port frame_err SHALL be output, width 1, sticky flag for a bad stop bit.
REQ-012 Port overrun SHALL be output, width 1, sticky flag for an unread byte overwritten.

Function
REQ-013 uartRx SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value rxs.
REQ-014 The tick counter SHALL free-run 0..BAUD_DIV-1, asserting tick for one clk when count==BAUD_DIV-1.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 In IDLE with rxs==0, the FSM SHALL go to START and clear s (tick count).
REQ-017 In START on the tick where s==7: rxs==0 SHALL go to DATA with s=0 and n=0; rxs==1 SHALL return to IDLE as a glitch, with no flags set.
REQ-018 In DATA on the tick where s==15, the block SHALL shift rxs into the shift register MSB (LSB-first line order), clear s and increment n; after bit n==DBIT-1 it SHALL go to STOP.
REQ-019 In STOP on the tick where s==SB_TICK-1 with rxs==1, the block SHALL load rx_data from the shift register, pulse rx_done, set data_available and go to IDLE.
REQ-020 In STOP on the tick where s==SB_TICK-1 with rxs==0, the block SHALL set frame_err, leave rx_data and data_available unchanged, and go to IDLE.
REQ-021 rx_done SHALL occur exactly 1 clk after the final stop-bit tick, registered.
REQ-022 rd_ack SHALL clear data_available, frame_err and overrun on the next edge.
REQ-023 rx_done with data_available==1 and rd_ack==0 SHALL overwrite rx_data and set overrun.
REQ-024 rx_done and rd_ack in the same cycle SHALL leave data_available=1 and SHALL NOT set overrun (set wins).
REQ-025 s SHALL be 4 bits and n SHALL be clog2(DBIT) bits, with no wrap beyond the terminal counts above.

Reset
REQ-026 Reset SHALL force the FSM to IDLE and clear s, n, the shift register and the tick counter.
REQ-027 Reset SHALL set rx_data=0, rx_done=0, data_available=0, frame_err=0 and overrun=0.
REQ-028 Reset SHALL preset the synchronizer to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no output change after release.
REQ-030 After reset release with the line low, the block SHALL treat the line as a start edge only once rxs is observed low in IDLE.

Structure
REQ-031 The FSM state encoding and the default BAUD_DIV/SB_TICK constants SHALL reside in the shared package uart_pkg.
REQ-032 The tick generator SHALL be the sub-module baud_tick_gen (parameter BAUD_DIV, ports clk, reset, tick).
REQ-033 The total RTL SHALL be within 120-400 lines.

Verification (bench BAUD_DIV=2, bit period 32 clk)
REQ-034 Send 0xA5 with a valid stop bit -> rx_done pulses once, rx_data=0xA5, data_available=1, frame_err=0.
REQ-035 Drive a 4-clk low glitch on an idle line -> FSM returns to IDLE, with no rx_done and no flags.
REQ-036 Send 0x3C with the stop bit held low -> frame_err=1, rx_data keeps its previous value, data_available unchanged.
REQ-037 Send 0x11 then 0x22 without rd_ack -> rx_data=0x22, overrun=1; then rd_ack -> all three flags 0.
REQ-038 Assert rd_ack in the same cycle as rx_done of 0x55 -> data_available=1, overrun=0.
REQ-039 Pulse reset during bit 4 of 0xFF, then send 0x81 -> rx_data=0x81 with no stale bits and no flags.
